// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared FSM encoding and arithmetic helpers for the PID controller
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_PTERM,
    S_ITERM,
    S_DTERM,
    S_SAT
  } pid_state_t;

  function automatic int acc_width(input int gw, input int iw);
    return gw + iw + 4;
  endfunction

  function automatic logic signed [63:0] clamp_s(input logic signed [63:0] v,
                                                 input logic signed [63:0] lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pid_ctrl_if.sv
// rtl/pid_ctrl_if.sv - sample-in / pwm-out bundle between speed estimator, PID and PWM generator
interface pid_ctrl_if #(
  parameter int DW = 8,
  parameter int OW = 8
);
  logic          sample_valid;
  logic [DW-1:0] setpoint;
  logic [DW-1:0] measured;
  logic          busy;
  logic          out_valid;
  logic [OW-1:0] pwm_mag;
  logic          pwm_dir;
  logic          sat_flag;
  logic          sample_drop;

  modport master (
    output sample_valid, setpoint, measured,
    input  busy, out_valid, pwm_mag, pwm_dir, sat_flag, sample_drop
  );

  modport slave (
    input  sample_valid, setpoint, measured,
    output busy, out_valid, pwm_mag, pwm_dir, sat_flag, sample_drop
  );
endinterface

// File: rtl/pid_sat.sv
// rtl/pid_sat.sv - fixed-point rescale, sign/magnitude split and output saturation
module pid_sat
  import pid_pkg::*;
#(
  parameter int AW   = 28,
  parameter int FRAC = 4,
  parameter int OW   = 8
) (
  input  logic signed [AW-1:0] acc,
  output logic [OW-1:0]        mag,
  output logic                 dir,
  output logic                 sat
);

  localparam logic [AW-1:0] MAG_MAX = AW'((1 << OW) - 1);

  logic signed [AW-1:0] r;
  logic [AW-1:0]        r_abs;

  always_comb begin
    r     = acc >>> FRAC;
    r_abs = $unsigned(r[AW-1] ? -r : r);
    dir   = ~r[AW-1];
    sat   = r_abs > MAG_MAX;
    mag   = sat ? MAG_MAX[OW-1:0] : r_abs[OW-1:0];
  end

endmodule

// File: rtl/pid_ctrl.sv
// rtl/pid_ctrl.sv - strobe-driven PID speed loop with one shared multiplier sequenced by an FSM
module pid_ctrl
  import pid_pkg::*;
#(
  parameter int DW      = 8,
  parameter int GW      = 8,
  parameter int FRAC    = 4,
  parameter int IW      = 16,
  parameter int INT_LIM = 2 ** (IW - 1) - 1,
  parameter int OW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  pid_ctrl_if.slave     bus,
  input  logic [GW-1:0] kp,
  input  logic [GW-1:0] ki,
  input  logic [GW-1:0] kd,
  input  logic          int_clr
);

  localparam int AW  = acc_width(GW, IW);
  localparam int EW  = DW + 1;
  localparam int DVW = DW + 2;
  localparam int VW  = (IW > DVW) ? IW : DVW;

  pid_state_t state, state_nxt;

  logic [DW-1:0]         sp_r, ms_r;
  logic [GW-1:0]         kp_r, ki_r, kd_r;
  logic signed [EW-1:0]  err, err_prev, err_c;
  logic signed [IW-1:0]  integ, integ_base, integ_clamped;
  logic signed [DVW-1:0] deriv;
  logic signed [AW-1:0]  acc, acc_base, acc_nxt;
  logic                  first, clr_pend, clr_now;
  logic signed [GW:0]    mul_a;
  logic signed [VW-1:0]  mul_b;
  logic signed [GW+VW:0] mul_p;
  logic [OW-1:0]         sat_mag, mag_r;
  logic                  sat_dir, sat_sat, dir_r, sat_r;
  logic                  out_valid_r, drop_r;

  // A clear seen mid-computation is parked in clr_pend and applied once back in IDLE.
  assign clr_now = (int_clr || clr_pend) && (state == S_IDLE || state == S_ERR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.sample_valid) state_nxt = S_ERR;
      S_ERR:   state_nxt = S_PTERM;
      S_PTERM: state_nxt = S_ITERM;
      S_ITERM: state_nxt = S_DTERM;
      S_DTERM: state_nxt = S_SAT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    err_c         = $signed({1'b0, sp_r}) - $signed({1'b0, ms_r});
    integ_base    = clr_now ? '0 : integ;
    integ_clamped = IW'(clamp_s(64'(integ_base) + 64'(err_c), 64'(INT_LIM)));
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_PTERM: begin mul_a = $signed({1'b0, kp_r}); mul_b = VW'(err);   end
      S_ITERM: begin mul_a = $signed({1'b0, ki_r}); mul_b = VW'(integ); end
      S_DTERM: begin mul_a = $signed({1'b0, kd_r}); mul_b = VW'(deriv); end
      default: ;
    endcase
    mul_p    = mul_a * mul_b;
    acc_base = (state == S_PTERM) ? '0 : acc;
    acc_nxt  = acc_base + AW'(mul_p);
  end

  // Saturation is evaluated on the final sum so the outputs are registered entering SAT.
  pid_sat #(.AW(AW), .FRAC(FRAC), .OW(OW)) u_sat (
    .acc (acc_nxt),
    .mag (sat_mag),
    .dir (sat_dir),
    .sat (sat_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      sp_r        <= '0;
      ms_r        <= '0;
      kp_r        <= '0;
      ki_r        <= '0;
      kd_r        <= '0;
      err         <= '0;
      err_prev    <= '0;
      integ       <= '0;
      deriv       <= '0;
      acc         <= '0;
      first       <= 1'b1;
      clr_pend    <= 1'b0;
      mag_r       <= '0;
      dir_r       <= 1'b1;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_r <= (state == S_DTERM);
      drop_r      <= bus.sample_valid && (state != S_IDLE);

      if (clr_now)
        clr_pend <= 1'b0;
      else if (int_clr && state != S_IDLE && state != S_ERR)
        clr_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (clr_now) begin
            integ    <= '0;
            err_prev <= '0;
            first    <= 1'b1;
          end
          if (bus.sample_valid) begin
            sp_r <= bus.setpoint;
            ms_r <= bus.measured;
            kp_r <= kp;
            ki_r <= ki;
            kd_r <= kd;
          end
        end
        S_ERR: begin
          err   <= err_c;
          integ <= integ_clamped;
          deriv <= (first || clr_now) ? '0 : DVW'(err_c) - DVW'(err_prev);
          if (clr_now) begin
            err_prev <= '0;
            first    <= 1'b1;
          end
        end
        S_PTERM, S_ITERM: acc <= acc_nxt;
        S_DTERM: begin
          acc      <= acc_nxt;
          err_prev <= err;
          first    <= 1'b0;
          mag_r    <= sat_mag;
          dir_r    <= sat_dir;
          sat_r    <= sat_sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.pwm_mag     = mag_r;
  assign bus.pwm_dir     = dir_r;
  assign bus.sat_flag    = sat_r;
  assign bus.sample_drop = drop_r;

endmodule
